// File: rtl/conv_encoder_framer_pkg.sv
// Shared widths, default generators and FSM encodings for the convolutional encoder framer.
// The widths here must line up with the decoder's PISO/SIPO stages.
package conv_encoder_framer_pkg;
   localparam int          SYM_W         = 2;
   localparam int          BITS_PER_BYTE = 8;
   localparam int          CW_W          = 16;
   localparam logic [2:0]  G0_DEF        = 3'b111;
   localparam logic [2:0]  G1_DEF        = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ENC  = 2'd1,
      S_OUT  = 2'd2
   } state_e;
endpackage

// File: rtl/conv_encoder_framer_bit.sv
// One K=3 rate-1/2 encoder step: combinational symbol from (b, sr) plus the
// registered shift-register update with synchronous clear.
module conv_enc_bit
   import conv_encoder_framer_pkg::*;
#(
   parameter logic [2:0] G0 = G0_DEF,
   parameter logic [2:0] G1 = G1_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             b_i,
   input  logic             shift_i,
   input  logic             clr_i,
   output logic [SYM_W-1:0] sym_o
);
   logic [1:0] sr_q, sr_d;
   logic [2:0] taps;

   assign taps  = {b_i, sr_q};
   assign sym_o = {^(G0 & taps), ^(G1 & taps)};

   // Clear wins over shift so a clear always starts the next bit from 00.
   always_comb begin
      sr_d = sr_q;
      if (clr_i) begin
         sr_d = 2'b00;
      end else if (shift_i) begin
         sr_d = {b_i, sr_q[1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= 2'b00;
      end else begin
         sr_q <= sr_d;
      end
   end
endmodule

// File: rtl/conv_encoder_framer.sv
// Accepts bytes, encodes them serially MSB first, and writes 16-bit codewords to the decoder FIFO.
// state  | meaning
// S_IDLE | ready for a byte; clear_i zeroes the encoder immediately
// S_ENC  | encoding one bit per cycle into the word register
// S_OUT  | word complete; strobe dvalid_o once busy_i is low
module conv_encoder_framer
   import conv_encoder_framer_pkg::*;
#(
   parameter logic [2:0] G0        = G0_DEF,
   parameter logic [2:0] G1        = G1_DEF,
   parameter int         CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_i,
   output logic                 byte_ready_o,
   input  logic                 clear_i,
   input  logic                 busy_i,
   output logic                 dvalid_o,
   output logic [CW_W-1:0]      data_o,
   output logic [CNT_WIDTH-1:0] word_cnt_o
);
   state_e                 state_q, state_d;
   logic [BITS_PER_BYTE-1:0] byte_q, byte_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [CW_W-1:0]        word_q, word_d;
   logic [CW_W-1:0]        data_q, data_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   clr_pend_q, clr_pend_d;
   logic                   rdy_q;
   logic                   shift, sr_clr, dvalid;
   logic [SYM_W-1:0]       sym;

   conv_enc_bit #(.G0(G0), .G1(G1)) u_enc (
      .clk     (clk),
      .rst_n   (rst_n),
      .b_i     (byte_q[BITS_PER_BYTE-1]),
      .shift_i (shift),
      .clr_i   (sr_clr),
      .sym_o   (sym)
   );

   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      bit_cnt_d    = bit_cnt_q;
      word_d       = word_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      clr_pend_d   = clr_pend_q;
      shift        = 1'b0;
      sr_clr       = 1'b0;
      dvalid       = 1'b0;
      byte_ready_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            byte_ready_o = rdy_q;
            sr_clr       = clear_i;
            if (byte_valid_i && rdy_q) begin
               byte_d    = byte_i;
               bit_cnt_d = 3'(BITS_PER_BYTE - 1);
               state_d   = S_ENC;
            end
         end
         S_ENC: begin
            shift  = 1'b1;
            byte_d = {byte_q[BITS_PER_BYTE-2:0], 1'b0};
            word_d = {word_q[CW_W-SYM_W-1:0], sym};
            if (clear_i) clr_pend_d = 1'b1;
            if (bit_cnt_q == 3'd0) begin
               state_d = S_OUT;
            end else begin
               bit_cnt_d = bit_cnt_q - 3'd1;
            end
         end
         S_OUT: begin
            if (clear_i) clr_pend_d = 1'b1;
            if (!busy_i) begin
               dvalid     = 1'b1;
               data_d     = word_q;
               cnt_d      = cnt_q + CNT_WIDTH'(1);
               // A clear seen during this word takes effect only after it is emitted.
               sr_clr     = clr_pend_q | clear_i;
               clr_pend_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dvalid_o   = dvalid;
   assign data_o     = dvalid ? word_q : data_q;
   assign word_cnt_o = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_q     <= '0;
         bit_cnt_q  <= '0;
         word_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         clr_pend_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         bit_cnt_q  <= bit_cnt_d;
         word_q     <= word_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         clr_pend_q <= clr_pend_d;
         rdy_q      <= 1'b1;
      end
   end
endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench: stimulus pushes hand-computed codewords, a monitor pops them on each strobe.
module tb_conv_encoder_framer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        byte_valid_i;
   logic [7:0]  byte_i;
   logic        clear_i;
   logic        busy_i;
   logic        byte_ready_o, dvalid_o;
   logic [15:0] data_o;
   logic [15:0] word_cnt_o;
   logic        byte_ready2, dvalid2;
   logic [15:0] data2;
   logic [1:0]  word_cnt2;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   exp_cnt = 0;

   conv_encoder_framer dut (
      .clk(clk), .rst_n(rst_n), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
      .byte_ready_o(byte_ready_o), .clear_i(clear_i), .busy_i(busy_i),
      .dvalid_o(dvalid_o), .data_o(data_o), .word_cnt_o(word_cnt_o)
   );

   conv_encoder_framer #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
      .byte_ready_o(byte_ready2), .clear_i(clear_i), .busy_i(busy_i),
      .dvalid_o(dvalid2), .data_o(data2), .word_cnt_o(word_cnt2)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         exp_cnt = 0;
      end else if (dvalid_o) begin
         chk("strobe_while_busy", {31'd0, busy_i}, 32'd0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got data %h expected no strobe", data_o);
         end else begin
            e = exp_q.pop_front();
            chk("data_o", {16'd0, data_o}, {16'd0, e.data});
            chk("word_cnt_at_strobe", {16'd0, word_cnt_o}, {16'd0, 16'(exp_cnt)});
            if (e.due >= 0) chk("latency_cycle", cyc, e.due);
         end
         exp_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic push, input logic [15:0] exp_w,
                            input logic clr, input logic lat);
      int k = 0;
      @(negedge clk);
      while (!byte_ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!byte_ready_o) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: byte_ready_o stuck at 0, required 1");
      end
      byte_valid_i = 1'b1;
      byte_i       = b;
      clear_i      = clr;
      if (push) exp_q.push_back('{exp_w, lat ? cyc + 9 : -1});
      @(posedge clk);
      #1;
      byte_valid_i = 1'b0;
      clear_i      = 1'b0;
   endtask

   // Called right after an accept: ready must stay low for 9 cycles then return.
   task automatic chk_ready_gap(input string name);
      logic seen_hi = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (byte_ready_o) seen_hi = 1'b1;
      end
      chk({name, "_low9"}, {31'd0, seen_hi}, 32'd0);
      @(negedge clk);
      chk({name, "_back_hi"}, {31'd0, byte_ready_o}, 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain_queue_empty", exp_q.size(), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00; clear_i = 1'b0; busy_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
      chk("rst_dvalid", {31'd0, dvalid_o}, 32'd0);
      chk("rst_data", {16'd0, data_o}, 32'h0);
      chk("rst_cnt", {16'd0, word_cnt_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, byte_ready_o}, 32'd1);

      // Single byte from sr=00.
      send_byte(8'h80, 1'b1, 16'hEC00, 1'b0, 1'b1);
      drain();
      chk("cnt_after_first", {16'd0, word_cnt_o}, 32'd1);
      chk("data_held", {16'd0, data_o}, 32'hEC00);

      // Back-to-back, state carried across bytes.
      send_byte(8'hFF, 1'b1, 16'hDAAA, 1'b0, 1'b1);
      chk_ready_gap("gap_ff");
      send_byte(8'h00, 1'b1, 16'h7000, 1'b0, 1'b1);
      chk_ready_gap("gap_00");
      drain();

      // Clear in IDLE together with the accepted byte.
      send_byte(8'hFF, 1'b1, 16'hDAAA, 1'b0, 1'b1);
      send_byte(8'h00, 1'b1, 16'h0000, 1'b1, 1'b1);
      drain();

      // Clear during encoding is deferred until the word is emitted.
      send_byte(8'hFF, 1'b1, 16'hDAAA, 1'b0, 1'b1);
      @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      send_byte(8'h00, 1'b1, 16'h0000, 1'b0, 1'b1);
      drain();

      // busy_i high for the first 5 cycles of S_OUT.
      send_byte(8'h80, 1'b1, 16'hEC00, 1'b0, 1'b0);
      busy_i = 1'b1;
      repeat (13) @(posedge clk);
      #1;
      chk("busy_no_strobe", exp_q.size(), 32'd1);
      busy_i = 1'b0;
      drain();
      chk("cnt_after_busy", {16'd0, word_cnt_o}, 32'd8);

      // Reset mid-word: nothing emitted, all state cleared.
      send_byte(8'hFF, 1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_dvalid", {31'd0, dvalid_o}, 32'd0);
      chk("midrst_ready", {31'd0, byte_ready_o}, 32'd0);
      chk("midrst_cnt", {16'd0, word_cnt_o}, 32'd0);
      chk("midrst_data", {16'd0, data_o}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(8'h80, 1'b1, 16'hEC00, 1'b0, 1'b1);
      drain();
      chk("cnt_four_words", {16'd0, word_cnt_o}, 32'd4);
      chk("cnt2_wrap", {30'd0, word_cnt2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
